// File: rtl/sd_dec_pkg.sv
// Shared definitions for the sigma-delta CIC decimator: filter order,
// modulator code mapping and output-width helper.
package sd_dec_pkg;

  localparam int unsigned CIC_ORDER = 3;

  typedef enum logic [1:0] {
    SD_NEG    = 2'b00,
    SD_ZERO_A = 2'b01,
    SD_ZERO_B = 2'b10,
    SD_POS    = 2'b11
  } sd_code_e;

  // Two-bit modulator code to a signed ternary value {-1, 0, +1}
  function automatic logic signed [1:0] sd_code_to_val(input logic [1:0] code);
    case (sd_code_e'(code))
      SD_NEG:  return -2'sd1;
      SD_POS:  return 2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

  // Bit growth of an order-3 CIC with unit differential delay
  function automatic int unsigned out_w_for(input int unsigned decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

endpackage

// File: rtl/sd_cic_stage.sv
// Single enable-gated register stage, used for both CIC integrators and
// comb delay elements.
module sd_cic_stage #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sigma_delta_decimator.sv
// Third-order CIC decimator for a ternary sigma-delta stream with a
// single-entry valid/ready output register and sticky overrun flag.
module sigma_delta_decimator
  import sd_dec_pkg::*;
#(
  parameter int unsigned DECIM = 64,
  parameter int unsigned OUT_W = out_w_for(DECIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sd_in,
  input  logic             sd_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int unsigned PH_W = $clog2(DECIM);

  logic [PH_W-1:0]  phase;
  logic             tick_c;
  logic signed [1:0] x_val;
  logic [OUT_W-1:0] x_ext;

  logic [OUT_W-1:0] integ_q  [CIC_ORDER];
  logic [OUT_W-1:0] integ_d  [CIC_ORDER];
  logic [OUT_W-1:0] comb_in  [CIC_ORDER];
  logic [OUT_W-1:0] comb_q   [CIC_ORDER];
  logic [OUT_W-1:0] comb_out [CIC_ORDER];

  assign tick_c = sd_valid && (phase == PH_W'(DECIM - 1));

  // Integrators chain combinationally so the comb sees this cycle's input;
  // all arithmetic wraps modulo 2^OUT_W by construction.
  always_comb begin
    x_val      = sd_code_to_val(sd_in);
    x_ext      = {{(OUT_W - 2){x_val[1]}}, x_val};
    integ_d[0] = integ_q[0] + x_ext;
    for (int unsigned i = 1; i < CIC_ORDER; i++) begin
      integ_d[i] = integ_q[i] + integ_d[i-1];
    end
    comb_in[0]  = integ_d[CIC_ORDER-1];
    comb_out[0] = comb_in[0] - comb_q[0];
    for (int unsigned i = 1; i < CIC_ORDER; i++) begin
      comb_in[i]  = comb_out[i-1];
      comb_out[i] = comb_in[i] - comb_q[i];
    end
  end

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_stage
    sd_cic_stage #(.W(OUT_W)) u_integ (
      .clk   (clk),
      .reset (reset),
      .en    (sd_valid),
      .d     (integ_d[g]),
      .q     (integ_q[g])
    );
    sd_cic_stage #(.W(OUT_W)) u_comb (
      .clk   (clk),
      .reset (reset),
      .en    (tick_c),
      .d     (comb_in[g]),
      .q     (comb_q[g])
    );
  end

  // Phase wraps naturally because DECIM is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (sd_valid) begin
      phase <= phase + PH_W'(1);
    end
  end

  // A new sample always wins over a pending one; dropping it raises overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (tick_c) begin
      out_data  <= comb_out[CIC_ORDER-1];
      out_valid <= 1'b1;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Self-checking bench for sigma_delta_decimator: vector table with an
// impulse-response reference model feeding a scoreboard, plus handshake corners.
module tb_sigma_delta_decimator;

  localparam int DECIM = 64;
  localparam int OUT_W = 20;
  localparam int HLEN  = 3 * DECIM - 2;

  logic             clk;
  logic             reset;
  logic [1:0]       sd_in;
  logic             sd_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  sigma_delta_decimator #(.DECIM(DECIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .sd_in     (sd_in),
    .sd_valid  (sd_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               cyc;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] code;
    bit         toggle;
    bit         rnd;
    int         frames;
    int         steady;
    int         start;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  int   h [HLEN];
  int   x_hist [$];
  exp_t sb [$];
  int   got [$];
  int   vcyc [$];
  exp_t mon_e;
  logic [OUT_W-1:0] last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int code_val(input logic [1:0] c);
    if (c == 2'b00) return -1;
    if (c == 2'b11) return 1;
    return 0;
  endfunction

  // Direct convolution of the accepted input history with the CIC impulse response
  function automatic longint model_out();
    longint s = 0;
    int n = x_hist.size();
    for (int j = 0; j < HLEN; j++) begin
      if (n - 1 - j >= 0) s += longint'(h[j]) * longint'(x_hist[n-1-j]);
    end
    return s;
  endfunction

  task automatic step(input logic [1:0] code, input logic v, input logic r);
    exp_t e;
    sd_in = code;
    sd_valid = v;
    out_ready = r;
    if (v) begin
      x_hist.push_back(code_val(code));
      if (x_hist.size() % DECIM == 0) begin
        e.data = OUT_W'(model_out());
        e.cyc  = cyc + 1;
        sb.push_back(e);
        last_exp = e.data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sd_valid = 1'b0;
    sd_in = 2'b01;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    x_hist.delete();
    sb.delete();
    got.delete();
    vcyc.delete();
  endtask

  // Scoreboard monitor: every accepted output transfer pops one expectation
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      got.push_back(int'($signed(out_data)));
      vcyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got sample %0d with nothing expected", $signed(out_data));
      end else begin
        mon_e = sb.pop_front();
        chk("sb_data", out_data, mon_e.data);
        chk("sb_latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vec [6];
    int b2 [2*DECIM-1];
    int acc, guard;
    logic [1:0] code;
    logic vld;
    logic [OUT_W-1:0] s1;

    vec[0] = '{"dc_pos",        2'b11, 1'b0, 1'b0, 6,  262144, 3};
    vec[1] = '{"dc_neg",        2'b00, 1'b0, 1'b0, 6, -262144, 3};
    vec[2] = '{"zero_01",       2'b01, 1'b0, 1'b0, 5,       0, 0};
    vec[3] = '{"zero_10",       2'b10, 1'b0, 1'b0, 5,       0, 0};
    vec[4] = '{"dc_pos_toggle", 2'b11, 1'b1, 1'b0, 6,  262144, 3};
    vec[5] = '{"random",        2'b01, 1'b0, 1'b1, 6,       0, 6};

    // Impulse response: length-DECIM boxcar convolved with itself three times
    for (int n = 0; n < 2*DECIM-1; n++) b2[n] = ((n < 2*DECIM-2-n) ? n : 2*DECIM-2-n) + 1;
    for (int n = 0; n < HLEN; n++) begin
      h[n] = 0;
      for (int k = 0; k < DECIM; k++) begin
        if (n - k >= 0 && n - k < 2*DECIM-1) h[n] += b2[n-k];
      end
    end

    reset = 1'b0;
    sd_in = 2'b01;
    sd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("por_out_data", out_data, 0);
    chk("por_out_valid", out_valid, 0);
    chk("por_overrun", overrun, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      mon_en = 1'b1;
      acc = 0;
      guard = 0;
      while (acc < vec[v].frames * DECIM && guard < 20000) begin
        if (vec[v].rnd) begin
          code = 2'($urandom_range(0, 3));
          vld  = ($urandom_range(0, 9) < 7);
        end else begin
          code = vec[v].code;
          vld  = 1'b1;
        end
        step(code, vld, 1'b1);
        if (vld) acc++;
        if (vec[v].toggle) step(code, 1'b0, 1'b1);
        guard++;
      end
      repeat (4) step(2'b01, 1'b0, 1'b1);
      mon_en = 1'b0;
      chk({vec[v].name, "_count"}, got.size(), vec[v].frames);
      chk({vec[v].name, "_sb_drain"}, sb.size(), 0);
      chk({vec[v].name, "_overrun"}, overrun, 0);
      for (int k = vec[v].start; k < got.size(); k++) begin
        chk({vec[v].name, "_steady"}, got[k], vec[v].steady);
      end
      if (!vec[v].rnd) begin
        for (int k = 1; k < vcyc.size(); k++) begin
          chk({vec[v].name, "_period"}, vcyc[k] - vcyc[k-1], vec[v].toggle ? 2*DECIM : DECIM);
        end
      end
    end

    // Two ticks with no consumer: second sample overwrites, overrun sticks
    do_reset();
    for (int i = 0; i < DECIM; i++) step(2'b11, 1'b1, 1'b0);
    s1 = last_exp;
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_overrun", overrun, 0);
    chk("ovr_first_data", out_data, s1);
    for (int i = 0; i < 10; i++) step(2'b11, 1'b1, 1'b0);
    chk("ovr_hold_data", out_data, s1);
    for (int i = 0; i < DECIM - 10; i++) step(2'b11, 1'b1, 1'b0);
    chk("ovr_second_overrun", overrun, 1);
    chk("ovr_second_valid", out_valid, 1);
    chk("ovr_second_data", out_data, last_exp);
    step(2'b11, 1'b0, 1'b1);
    chk("ovr_consumed_valid", out_valid, 0);
    chk("ovr_sticky", overrun, 1);
    step(2'b11, 1'b0, 1'b1);
    chk("ovr_sticky2", overrun, 1);

    // Tick in the same cycle as a handshake replaces the sample without overrun
    do_reset();
    for (int i = 0; i < DECIM; i++) step(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < DECIM - 1; i++) step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b1);
    chk("coinc_valid", out_valid, 1);
    chk("coinc_data", out_data, last_exp);
    chk("coinc_overrun", overrun, 0);
    step(2'b11, 1'b0, 1'b1);
    chk("coinc_consumed", out_valid, 0);

    // Mid-frame asynchronous reset at phase 30 with output pending and overrun set
    do_reset();
    for (int i = 0; i < 2*DECIM + 30; i++) step(2'b11, 1'b1, 1'b0);
    chk("mid_pre_overrun", overrun, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    x_hist.delete();
    sb.delete();
    for (int i = 0; i < DECIM - 1; i++) step(2'b11, 1'b1, 1'b1);
    chk("mid_no_partial", out_valid, 0);
    step(2'b11, 1'b1, 1'b1);
    chk("mid_first_valid", out_valid, 1);
    chk("mid_first_data", out_data, last_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sigma_delta_decimator.md
SIGMA_DELTA_DECIMATOR -- requirements
Module: sigma_delta_decimator

Interface
REQ-001 SHALL have parameter DECIM, default 64: decimation ratio; power of two, 4..256.
REQ-002 SHALL have parameter OUT_W, default 2+3*log2(DECIM) (20 at default): output sample width, two's complement.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sd_in  input  2  modulator stream from sigma_delta_twopiece sd_out.
REQ-006 SHALL have port sd_valid  input  1  sd_in is sampled this cycle.
REQ-007 SHALL have port out_data  output  OUT_W  decimated signed sample.
REQ-008 SHALL have port out_valid  output  1  out_data holds an unconsumed sample.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-010 SHALL have port overrun  output  1  sticky flag: a sample was dropped.

Function
REQ-011 SHALL map sd_in to x in {-1,0,+1}: 2'b00 -> -1, 2'b01 or 2'b10 -> 0, 2'b11 -> +1.
REQ-012 SHALL implement a 3rd-order CIC: three cascaded integrators at input rate, three differential-delay-1 combs at output rate.
REQ-013 Integrators SHALL be OUT_W bits and wrap modulo 2^OUT_W; wrap is legal and SHALL NOT be detected or saturated.
REQ-014 Integrators and the phase counter SHALL advance only in cycles with sd_valid=1; with sd_valid=0 all state SHALL hold.
REQ-015 The phase counter (log2(DECIM) bits) SHALL count accepted inputs 0..DECIM-1 and wrap to 0; the accepted input at count DECIM-1 is the decimation tick.
REQ-016 On a tick, the comb chain SHALL process the last-integrator value (including that tick's input) and the result SHALL be registered into out_data at the same edge, making out_valid=1 from the following cycle: one-clock latency from the tick input.
REQ-017 Comb delay registers SHALL update only on ticks.
REQ-018 out_valid SHALL clear at the edge where out_valid=1 and out_ready=1, unless a new tick occurs in that cycle, in which case out_data is replaced and out_valid stays 1.
REQ-019 If a tick occurs while out_valid=1 and out_ready=0, out_data SHALL be overwritten with the new sample, out_valid SHALL stay 1, and overrun SHALL set.
REQ-020 overrun SHALL be cleared only by reset.
REQ-021 out_data SHALL stay stable while out_valid=1 and no tick occurs.
REQ-022 At steady DC input x, out_data SHALL settle to x*DECIM^3 from the 4th output sample after reset onward.

Reset
REQ-023 Asserting reset (low) SHALL immediately clear all integrators, comb delays, phase counter, out_data (0), out_valid (0) and overrun (0), including mid-frame.
REQ-024 After reset deasserts, the first accepted input SHALL be phase 0; no partial frame SHALL be emitted.

Structure
REQ-025 A shared package sd_dec_pkg SHALL hold the CIC order constant (3), the sd_in code-to-value mapping, and a function computing OUT_W from DECIM.
REQ-026 One sub-module sd_cic_stage SHALL implement a single enable-gated OUT_W-bit register stage, instantiated for integrators (enable=sd_valid) and comb delays (enable=tick).
REQ-027 Combs SHALL be combinational between tick registration points; no multipliers SHALL be used.

Verification
REQ-028 Reset, then sd_in=2'b11, sd_valid=1 continuously, out_ready=1 -> out_valid pulses once per 64 clocks, samples 4+ equal +262144, overrun=0.
REQ-029 Constant sd_in=2'b00 -> samples 4+ equal -262144; constant 2'b01 -> every sample 0.
REQ-030 sd_valid toggling 1/0 each cycle with sd_in=2'b11 -> out_valid every 128 clocks, same steady value +262144.
REQ-031 out_ready=0 held through two ticks -> overrun=1 after the second tick, out_data equals the second sample, out_valid stays 1; overrun remains 1 after out_ready returns to 1.
REQ-032 Assert reset for one cycle at input phase 30 -> all outputs 0 immediately; next out_valid appears exactly 64 accepted inputs after release.
REQ-033 Feed sigma_delta_twopiece output with kin=40'h00154165e9 -> decimated stream matches a bit-true Python CIC model sample-for-sample.
